normalize_32: RTL and testbench



---
 rtl/normalize_32_pkg.sv | 14 +
 rtl/normalize_32.sv | 96 +++++++++
 tb/tb_normalize_32.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/normalize_32_pkg.sv
// Shared constants for the normaliser: FSM state encoding and shift-direction
// values (same meaning as the shift/rotate unit's in_left).
package normalize_32_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/normalize_32.sv
// Multi-cycle normaliser: shifts the operand one bit per clock until the leading
// (left) or trailing (right) 1 reaches the edge, reporting result and shift count.
module normalize_32
  import normalize_32_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_x,
  input  logic             in_left,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_result,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero,
  output logic [1:0]       out_state
);

  // Handshake: in_start is taken on any edge where the unit is not busy
  // (IDLE or DONE); out_done is a one-cycle pulse in DONE, and a start held
  // high in DONE is accepted in that same cycle.

  state_t           state, state_n;
  logic [WIDTH-1:0] result, result_n;
  logic [CNT_W-1:0] count, count_n;
  logic             zero, zero_n;
  logic             dir, dir_n;
  logic             at_edge;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state  <= IDLE;
      result <= '0;
      count  <= '0;
      zero   <= 1'b0;
      dir    <= DIR_RIGHT;
    end else begin
      state  <= state_n;
      result <= result_n;
      count  <= count_n;
      zero   <= zero_n;
      dir    <= dir_n;
    end
  end

  // Termination test: the bit we are normalising toward is already set.
  assign at_edge = (dir == DIR_LEFT) ? result[WIDTH-1] : result[0];

  always_comb begin
    state_n  = state;
    result_n = result;
    count_n  = count;
    zero_n   = zero;
    dir_n    = dir;
    case (state)
      IDLE, DONE: begin
        if (in_start) begin
          if (in_x == '0) begin
            result_n = '0;
            count_n  = CNT_W'(WIDTH);
            zero_n   = 1'b1;
            state_n  = DONE;
          end else begin
            result_n = in_x;
            count_n  = '0;
            zero_n   = 1'b0;
            dir_n    = in_left;
            state_n  = SHIFT;
          end
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (at_edge) begin
          state_n = DONE;
        end else begin
          result_n = (dir == DIR_LEFT) ? (result << 1) : (result >> 1);
          count_n  = count + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_busy   = (state == SHIFT);
  assign out_done   = (state == DONE);
  assign out_result = result;
  assign out_count  = count;
  assign out_zero   = zero;
  assign out_state  = state;

endmodule

// File: tb/tb_normalize_32.sv
// Self-checking bench for normalize_32: directed plan steps plus random operands
// compared against an arithmetic zero-count model.
module tb_normalize_32;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_start;
  logic [31:0] in_x;
  logic        in_left;
  logic        out_busy;
  logic        out_done;
  logic [31:0] out_result;
  logic [5:0]  out_count;
  logic        out_zero;
  logic [1:0]  out_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 in_clk = ~in_clk;

  normalize_32 dut (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_start  (in_start),
    .in_x      (in_x),
    .in_left   (in_left),
    .out_busy  (out_busy),
    .out_done  (out_done),
    .out_result(out_result),
    .out_count (out_count),
    .out_zero  (out_zero),
    .out_state (out_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  // Number of zeros between the operand's edge and its first 1; 32 for zero.
  function automatic int ref_zeros(input logic [31:0] x, input logic left);
    int n = 0;
    if (x == 32'd0) return 32;
    if (left) while (x[31-n] == 1'b0) n++;
    else      while (x[n] == 1'b0) n++;
    return n;
  endfunction

  task automatic run_op(input logic [31:0] x, input logic left, input string tag);
    int n, edges, busy_cnt, exp_lat;
    logic [31:0] er, shifted;
    n  = ref_zeros(x, left);
    er = (n == 32) ? 32'd0 : (left ? (x << n) : (x >> n));
    exp_q.push_back(er);
    exp_lat = (n == 32) ? 1 : n + 2;
    in_x = x; in_left = left; in_start = 1'b1;
    step();
    in_start = 1'b0;
    in_x = $urandom;
    in_left = 1'($urandom_range(0, 1));
    edges = 1; busy_cnt = 0;
    while (!out_done && edges < 40) begin
      if (out_busy) busy_cnt++;
      step();
      edges++;
    end
    check($sformatf("%s done", tag), 64'(out_done), 64'd1);
    check($sformatf("%s latency", tag), 64'(edges), 64'(exp_lat));
    check($sformatf("%s busy_cycles", tag), 64'(busy_cnt), 64'((n == 32) ? 0 : n + 1));
    check($sformatf("%s result", tag), 64'(out_result), 64'(exp_q.pop_front()));
    check($sformatf("%s count", tag), 64'(out_count), 64'(n));
    check($sformatf("%s zero", tag), 64'(out_zero), 64'(x == 32'd0));
    if (x != 32'd0) begin
      shifted = left ? (x << out_count) : (x >> out_count);
      check($sformatf("%s shift_roundtrip", tag), 64'(shifted), 64'(out_result));
    end
    step();
    check($sformatf("%s done_pulse", tag), 64'(out_done), 64'd0);
    check($sformatf("%s back_idle", tag), 64'(out_state), 64'd0);
  endtask

  initial begin
    int edges;
    logic seen;
    logic [31:0] rx;
    in_rst = 1'b1; in_start = 1'b0; in_x = '0; in_left = 1'b0;
    step();
    step();
    in_rst = 1'b0;
    check("reset busy", 64'(out_busy), 64'd0);
    check("reset done", 64'(out_done), 64'd0);
    check("reset result", 64'(out_result), 64'd0);
    check("reset count", 64'(out_count), 64'd0);
    check("reset zero", 64'(out_zero), 64'd0);
    check("reset state", 64'(out_state), 64'd0);

    run_op(32'h0000F000, 1'b1, "f000_left");
    run_op(32'h0000F000, 1'b0, "f000_right");
    run_op(32'h80000001, 1'b1, "msb_lsb_left");
    run_op(32'h80000001, 1'b0, "msb_lsb_right");
    run_op(32'h00000000, 1'b1, "zero_left");
    run_op(32'h00000000, 1'b0, "zero_right");
    run_op(32'h00000001, 1'b1, "one_left_max");
    run_op(32'h80000000, 1'b0, "msb_right_max");

    // Random operands with a spread of zero counts in both directions.
    for (int i = 0; i < 30; i++) begin
      rx = $urandom;
      case ($urandom_range(0, 3))
        0: rx = rx >> $urandom_range(0, 31);
        1: rx = rx << $urandom_range(0, 31);
        2: rx = 32'd1 << $urandom_range(0, 31);
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) rx = 32'd0;
      run_op(rx, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    // Start while busy is ignored; reset mid-SHIFT abandons the operation.
    in_x = 32'h00000001; in_left = 1'b1; in_start = 1'b1;
    step();
    in_start = 1'b0;
    step();
    in_start = 1'b1; in_x = 32'd0; in_left = 1'b0;
    step();
    in_start = 1'b0;
    edges = 0;
    while (out_count != 6'd10 && edges < 40) begin
      step();
      edges++;
    end
    check("busy_start count10", 64'(out_count), 64'd10);
    check("busy_start still_busy", 64'(out_busy), 64'd1);
    check("busy_start zero", 64'(out_zero), 64'd0);
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    check("midrst result", 64'(out_result), 64'd0);
    check("midrst count", 64'(out_count), 64'd0);
    check("midrst zero", 64'(out_zero), 64'd0);
    check("midrst busy", 64'(out_busy), 64'd0);
    check("midrst done", 64'(out_done), 64'd0);
    check("midrst state", 64'(out_state), 64'd0);
    seen = 1'b0;
    repeat (5) begin
      step();
      if (out_done) seen = 1'b1;
    end
    check("midrst no_done", 64'(seen), 64'd0);

    // Start held high: the second operation is accepted in the DONE cycle.
    in_x = 32'h40000000; in_left = 1'b1; in_start = 1'b1;
    step();
    in_x = 32'h00000002; in_left = 1'b0;
    edges = 1;
    while (!out_done && edges < 40) begin
      step();
      edges++;
    end
    check("b2b1 latency", 64'(edges), 64'd3);
    check("b2b1 result", 64'(out_result), 64'h80000000);
    check("b2b1 count", 64'(out_count), 64'd1);
    step();
    in_start = 1'b0;
    check("b2b1 done_pulse", 64'(out_done), 64'd0);
    check("b2b2 accepted", 64'(out_busy), 64'd1);
    edges = 1;
    while (!out_done && edges < 40) begin
      step();
      edges++;
    end
    check("b2b2 latency", 64'(edges), 64'd3);
    check("b2b2 result", 64'(out_result), 64'h00000001);
    check("b2b2 count", 64'(out_count), 64'd1);
    step();
    check("b2b2 done_pulse", 64'(out_done), 64'd0);
    check("b2b2 idle", 64'(out_state), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
